display_scheduler: RTL and testbench

//  Owns the shared 7-seg SPI display engine (display_spi) and the NUM_CHAN displays on its bus.

---
 rtl/display_scheduler_pkg.sv | 23 ++
 rtl/display_scheduler_rr_pick.sv | 44 ++++
 rtl/display_scheduler.sv | 142 ++++++++++++++
 tb/tb_display_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module  : display_scheduler_pkg
// Brief   : Shared state encodings and defaults for the 7-seg display scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package display_scheduler_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_SYNC  = 3'd0;
    localparam state_t S_IDLE  = 3'd1;
    localparam state_t S_START = 3'd2;
    localparam state_t S_ACK   = 3'd3;
    localparam state_t S_WAIT  = 3'd4;

    localparam int c_NUM_CHAN_DEF       = 4;
    localparam int c_REFRESH_CYCLES_DEF = 12_000_000;

endpackage

`default_nettype wire

// File: rtl/display_scheduler_rr_pick.sv
//------------------------------------------------------------------------------
// Module  : display_scheduler_rr_pick
// Brief   : Combinational round-robin picker: first set bit at or after rr_ptr.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module display_scheduler_rr_pick
    import display_scheduler_pkg::*;
#(
    parameter int NUM_CHAN = c_NUM_CHAN_DEF,
    parameter int CHAN_W   = $clog2(NUM_CHAN)
) (
    input  logic [NUM_CHAN-1:0] pending,
    input  logic [CHAN_W-1:0]   rr_ptr,
    output logic                any,
    output logic [CHAN_W-1:0]   chan
);

    int                w_sum;
    logic [CHAN_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest pending bit wins.
    always_comb begin
        any   = 1'b0;
        chan  = '0;
        w_sum = 0;
        w_idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            w_sum = int'(rr_ptr) + i;
            if (w_sum >= NUM_CHAN) begin
                w_sum = w_sum - NUM_CHAN;
            end
            w_idx = CHAN_W'(w_sum);
            if (pending[w_idx]) begin
                any  = 1'b1;
                chan = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_scheduler.sv
//------------------------------------------------------------------------------
// Module  : display_scheduler
// Brief   : Round-robin owner of the shared display_spi engine for NUM_CHAN
//           7-seg displays. Optional periodic refresh via DISPLAY_REFRESH_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int NUM_CHAN       = c_NUM_CHAN_DEF,
    parameter int CHAN_W         = $clog2(NUM_CHAN),
    parameter int REFRESH_CYCLES = c_REFRESH_CYCLES_DEF
) (
    input  logic                raw_clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [15:0]         wr_data,
    input  logic                spi_busy,
    output logic                spi_start,
    output logic [15:0]         spi_data,
    output logic [NUM_CHAN-1:0] spi_sel,
    output logic                idle
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_value [NUM_CHAN];
    logic [NUM_CHAN-1:0] r_pending;
    logic [NUM_CHAN-1:0] w_pending_nxt;
    logic [CHAN_W-1:0]   r_rr_ptr;
    logic [CHAN_W-1:0]   w_rr_ptr_nxt;
    logic [15:0]         r_spi_data;
    logic [NUM_CHAN-1:0] r_spi_sel;
    logic [NUM_CHAN-1:0] w_sel_onehot;
    logic                r_idle;
    logic                w_any;
    logic [CHAN_W-1:0]   w_pick_chan;
    logic                w_pick;
    logic                w_wr_ok;
    logic                w_refresh_tick;

    display_scheduler_rr_pick #(
        .NUM_CHAN (NUM_CHAN),
        .CHAN_W   (CHAN_W)
    ) u_rr_pick (
        .pending (r_pending),
        .rr_ptr  (r_rr_ptr),
        .any     (w_any),
        .chan    (w_pick_chan)
    );

`ifdef DISPLAY_REFRESH_EN
    localparam int c_REF_W = $clog2(REFRESH_CYCLES);

    logic [c_REF_W-1:0] r_refresh_cnt;

    always_ff @(posedge raw_clk) begin
        if (reset || (r_refresh_cnt == '0)) begin
            r_refresh_cnt <= c_REF_W'(REFRESH_CYCLES - 1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt - c_REF_W'(1);
        end
    end

    assign w_refresh_tick = (r_refresh_cnt == '0) && !reset;
`else
    // Refresh compiled out: the tick is a constant that never fires.
    assign w_refresh_tick = (REFRESH_CYCLES == 0);
`endif

    // State and datapath registers.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            r_state    <= S_SYNC;
            r_pending  <= '1;
            r_rr_ptr   <= '0;
            r_spi_data <= '0;
            r_spi_sel  <= '0;
            r_idle     <= 1'b0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_value[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_idle    <= (w_state_nxt == S_IDLE) && (w_pending_nxt == '0);
            if (w_wr_ok) begin
                r_value[wr_chan] <= wr_data;
            end
            if (w_pick) begin
                r_spi_data <= r_value[w_pick_chan];
                r_spi_sel  <= w_sel_onehot;
                r_rr_ptr   <= w_rr_ptr_nxt;
            end else if ((r_state == S_WAIT) && !spi_busy) begin
                r_spi_sel  <= '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SYNC:  if (!spi_busy) w_state_nxt = S_IDLE;
            S_IDLE:  if (w_any)     w_state_nxt = S_START;
            S_START:                w_state_nxt = S_ACK;
            S_ACK:   if (spi_busy)  w_state_nxt = S_WAIT;
            S_WAIT:  if (!spi_busy) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_SYNC;
        endcase
    end

    // Output and pending-set logic; a write lands after the pick clear so it wins.
    always_comb begin
        spi_start     = (r_state == S_START);
        w_pick        = (r_state == S_IDLE) && w_any;
        w_wr_ok       = wr_en && (int'(wr_chan) < NUM_CHAN);
        w_sel_onehot  = '0;
        w_sel_onehot[w_pick_chan] = 1'b1;
        w_rr_ptr_nxt  = (w_pick_chan == CHAN_W'(NUM_CHAN - 1)) ? '0 : w_pick_chan + CHAN_W'(1);
        w_pending_nxt = r_pending;
        if (w_pick) begin
            w_pending_nxt[w_pick_chan] = 1'b0;
        end
        if (w_refresh_tick) begin
            w_pending_nxt = '1;
        end
        if (w_wr_ok) begin
            w_pending_nxt[wr_chan] = 1'b1;
        end
    end

    assign spi_data = r_spi_data;
    assign spi_sel  = r_spi_sel;
    assign idle     = r_idle;

endmodule

`default_nettype wire

// File: tb/tb_display_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_display_scheduler
// Brief   : Directed bench for display_scheduler with a display_spi busy model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_scheduler;

    localparam int NUM_CHAN       = 4;
    localparam int CHAN_W         = 2;
    localparam int REFRESH_CYCLES = 200;

    logic        raw_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        wr_en   = 1'b0;
    logic [1:0]  wr_chan = 2'd0;
    logic [15:0] wr_data = 16'd0;
    logic        spi_busy;
    logic        spi_start;
    logic [15:0] spi_data;
    logic [3:0]  spi_sel;
    logic        idle;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] data;
        int          t;
    } frame_t;

    frame_t log_q[$];
    int     busy_cnt   = 0;
    bit     hold_req   = 1'b0;
    int     cyc        = 0;
    int     total      = 0;
    int     bad        = 0;
    bit     prev_start = 1'b0;

    always #5 raw_clk = ~raw_clk;

    display_scheduler #(
        .NUM_CHAN       (NUM_CHAN),
        .CHAN_W         (CHAN_W),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .raw_clk   (raw_clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_chan   (wr_chan),
        .wr_data   (wr_data),
        .spi_busy  (spi_busy),
        .spi_start (spi_start),
        .spi_data  (spi_data),
        .spi_sel   (spi_sel),
        .idle      (idle)
    );

    // display_spi model: busy one cycle after start, 40 cycles long, no reset.
    assign spi_busy = (busy_cnt != 0);

    always @(posedge raw_clk) begin
        cyc <= cyc + 1;
        if (hold_req) begin
            busy_cnt <= 20;
        end else if (spi_start) begin
            busy_cnt <= 40;
            log_q.push_back('{spi_sel, spi_data, cyc});
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(negedge raw_clk) begin
        assert (!(spi_start && spi_busy)) else begin
            bad++;
            $error("FAIL start_while_busy observed=1 expected=0");
        end
        assert (!(spi_start && prev_start)) else begin
            bad++;
            $error("FAIL start_twice observed=1 expected=0");
        end
        assert ($onehot0(spi_sel)) else begin
            bad++;
            $error("FAIL sel_onehot observed=%b expected=onehot0", spi_sel);
        end
        prev_start = spi_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [3:0] sel,
                               input logic [15:0] data);
        logic [31:0] obs;
        obs = 'x;
        if (idx < log_q.size()) obs = {12'd0, log_q[idx].sel, log_q[idx].data};
        check(tag, obs, {12'd0, sel, data});
    endtask

    task automatic check_sel(input string tag, input int idx, input logic [3:0] sel);
        logic [31:0] obs;
        obs = 'x;
        if (idx < log_q.size()) obs = {28'd0, log_q[idx].sel};
        check(tag, obs, {28'd0, sel});
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && idle !== 1'b1; i++) @(negedge raw_clk);
        check(tag, {31'd0, idle}, 32'd1);
    endtask

    task automatic wait_busy(input string tag, input logic val, input int max);
        for (int i = 0; i < max && spi_busy !== val; i++) @(negedge raw_clk);
        check(tag, {31'd0, spi_busy}, {31'd0, val});
    endtask

    task automatic wr(input logic [1:0] ch, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_chan = ch;
        wr_data = d;
        @(negedge raw_clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        // 1: reset state and the power-up burst of blank frames
        repeat (3) @(negedge raw_clk);
        check("rst_start", {31'd0, spi_start}, 32'd0);
        check("rst_sel",   {28'd0, spi_sel},   32'd0);
        check("rst_data",  {16'd0, spi_data},  32'd0);
        check("rst_idle",  {31'd0, idle},      32'd0);
        reset = 1'b0;
        wait_idle("t1_idle", 1000);
        check("t1_count", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_frame("t1_frame", i, 4'(1 << i), 16'h0000);

`ifdef DISPLAY_REFRESH_EN
        // 6: periodic refresh bursts, 200 cycles apart
        log_q.delete();
        for (int i = 0; i < 1000 && log_q.size() < 8; i++) @(negedge raw_clk);
        check("t6_count", log_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) check_frame("t6_frame", i, 4'(1 << (i % 4)), 16'h0000);
        check("t6_gap", (log_q.size() >= 8) ? 32'(log_q[4].t - log_q[0].t) : 32'hFFFF_FFFF,
              32'd200);
`else
        // 2: single write while idle, start latency and captured data
        log_q.delete();
        check("t2_pre_idle", {31'd0, idle}, 32'd1);
        wr_en = 1'b1; wr_chan = 2'd2; wr_data = 16'h1234;
        @(negedge raw_clk);
        wr_en = 1'b0;
        check("t2_e0_start", {31'd0, spi_start}, 32'd0);
        check("t2_e0_idle",  {31'd0, idle},      32'd0);
        @(negedge raw_clk);
        check("t2_start", {31'd0, spi_start}, 32'd1);
        check("t2_sel",   {28'd0, spi_sel},   32'h4);
        check("t2_data",  {16'd0, spi_data},  32'h1234);
        wait_idle("t2_idle", 500);
        check("t2_count", log_q.size(), 32'd1);
        check_frame("t2_frame", 0, 4'b0100, 16'h1234);

        // 3: write to the in-flight channel during S_WAIT
        log_q.delete();
        wr(2'd1, 16'h5555);
        wait_busy("t3_busy", 1'b1, 20);
        repeat (5) @(negedge raw_clk);
        wr(2'd1, 16'hAAAA);
        check("t3_hold_data", {16'd0, spi_data}, 32'h5555);
        check("t3_hold_sel",  {28'd0, spi_sel},  32'h2);
        wait_idle("t3_idle", 500);
        check("t3_count", log_q.size(), 32'd2);
        check_frame("t3_frame0", 0, 4'b0010, 16'h5555);
        check_frame("t3_frame1", 1, 4'b0010, 16'hAAAA);

        // 5: reset mid-S_WAIT while the engine keeps running
        log_q.delete();
        wr(2'd2, 16'h7777);
        wait_busy("t5_busy", 1'b1, 20);
        repeat (5) @(negedge raw_clk);
        reset = 1'b1; hold_req = 1'b1;
        @(negedge raw_clk);
        reset = 1'b0; hold_req = 1'b0;
        check("t5_sel",   {28'd0, spi_sel},   32'd0);
        check("t5_data",  {16'd0, spi_data},  32'd0);
        check("t5_start", {31'd0, spi_start}, 32'd0);
        check("t5_idle",  {31'd0, idle},      32'd0);
        log_q.delete();
        wait_busy("t5_drain", 1'b0, 100);
        check("t5_no_start", log_q.size(), 32'd0);
        wait_idle("t5_idle_end", 1000);
        check("t5_count", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_frame("t5_frame", i, 4'(1 << i), 16'h0000);

        // 4: ch0 rewritten every cycle cannot starve ch1/ch3
        log_q.delete();
        wr(2'd3, 16'h3333);
        wait_busy("t4_busy", 1'b1, 20);
        wr(2'd3, 16'h3334);
        wr(2'd1, 16'h1111);
        for (int i = 0; i < 2000 && log_q.size() < 5; i++) begin
            wr_en = 1'b1; wr_chan = 2'd0; wr_data = 16'hC000 | 16'(i);
            @(negedge raw_clk);
        end
        wr_en = 1'b0;
        check_frame("t4_f0", 0, 4'b1000, 16'h3333);
        check_sel("t4_f1", 1, 4'b0001);
        check_frame("t4_f2", 2, 4'b0010, 16'h1111);
        check_frame("t4_f3", 3, 4'b1000, 16'h3334);
        check_sel("t4_f4", 4, 4'b0001);
        wait_idle("t4_idle", 1000);

        // 6 (default build): no refresh frames
        log_q.delete();
        repeat (500) @(negedge raw_clk);
        check("t6_no_frames", log_q.size(), 32'd0);
        check("t6_idle", {31'd0, idle}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
